// File: rtl/calc_display.sv
// Display stage for the calculator accumulator: sequential double-dabble binary-to-BCD
// conversion feeding a multiplexed, active-low, common-anode seven-segment display.
module calc_display #(
   parameter int BITS        = 32,
   parameter int DIGITS      = 8,
   parameter int REFRESH_CNT = 100000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [BITS-1:0]   accum,
   output logic [DIGITS-1:0] anode,
   output logic [7:0]        cathode,
   output logic              busy,
   output logic              ovf
);

   // ceil(BITS * log10(2)) in integer arithmetic
   localparam int NBCD  = (BITS * 30103 + 99999) / 100000;
   localparam int NSHOW = (DIGITS > NBCD) ? DIGITS : NBCD;
   localparam int SW    = NBCD * 4 + BITS;
   localparam int BW    = $clog2(BITS + 1);
   localparam int RW    = $clog2(REFRESH_CNT);
   localparam int DW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

   state_t             state;
   logic [BITS-1:0]    shadow;
   logic [SW-1:0]      sreg;
   logic [SW-1:0]      sreg_adj;
   logic [BW-1:0]      bitcnt;
   logic [NSHOW*4-1:0] disp;
   logic [NSHOW*4-1:0] bcd_ext;
   logic               ovf_next;

   logic [RW-1:0]      rcnt;
   logic [DW-1:0]      dig;
   logic [3:0]         nib;
   logic [DIGITS-1:0]  blank;
   logic               blank_sel;
   logic               zero_above;
   logic [6:0]         seg;
   logic               dp;

   // Add-3 correction on every BCD nibble before the shift
   always_comb begin
      sreg_adj = sreg;
      for (int i = 0; i < NBCD; i++) begin
         if (sreg[BITS + 4*i +: 4] >= 4'd5)
            sreg_adj[BITS + 4*i +: 4] = sreg[BITS + 4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      bcd_ext = '0;
      bcd_ext[NBCD*4-1:0] = sreg[SW-1:BITS];
      ovf_next = 1'b0;
      for (int i = DIGITS; i < NBCD; i++)
         ovf_next = ovf_next | (sreg[BITS + 4*i +: 4] != 4'd0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         shadow <= '0;
         sreg   <= '0;
         bitcnt <= '0;
         disp   <= '0;
         busy   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accum != shadow) begin
                  shadow <= accum;
                  sreg   <= {{(NBCD*4){1'b0}}, accum};
                  bitcnt <= '0;
                  busy   <= 1'b1;
                  state  <= CONVERT;
               end
            end
            CONVERT: begin
               sreg   <= sreg_adj << 1;
               bitcnt <= bitcnt + BW'(1);
               if (bitcnt == BW'(BITS - 1))
                  state <= UPDATE;
            end
            UPDATE: begin
               disp  <= bcd_ext;
               ovf   <= ovf_next;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Digit scan runs freely, independent of the converter
   always_ff @(posedge clk) begin
      if (reset) begin
         rcnt <= '0;
         dig  <= '0;
      end else if (rcnt == RW'(REFRESH_CNT - 1)) begin
         rcnt <= '0;
         dig  <= (dig == DW'(DIGITS - 1)) ? '0 : dig + DW'(1);
      end else begin
         rcnt <= rcnt + RW'(1);
      end
   end

   // Digit k blanks when it and every digit above it (within the display) are zero
   always_comb begin
      zero_above = 1'b1;
      blank      = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         zero_above = zero_above & (disp[4*k +: 4] == 4'd0);
         blank[k]   = (k != 0) && zero_above;
      end
   end

   always_comb begin
      nib       = 4'd0;
      blank_sel = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (dig == DW'(k)) begin
            nib       = disp[4*k +: 4];
            blank_sel = blank[k];
         end
      end
   end

   always_comb begin
      case (nib)
         4'd0:    seg = 7'h40;
         4'd1:    seg = 7'h79;
         4'd2:    seg = 7'h24;
         4'd3:    seg = 7'h30;
         4'd4:    seg = 7'h19;
         4'd5:    seg = 7'h12;
         4'd6:    seg = 7'h02;
         4'd7:    seg = 7'h78;
         4'd8:    seg = 7'h00;
         4'd9:    seg = 7'h10;
         default: seg = 7'h7F;
      endcase
      dp = (dig == DW'(DIGITS - 1)) ? ~ovf : 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         anode   <= '1;
         cathode <= 8'hFF;
      end else begin
         anode   <= ~(DIGITS'(1) << dig);
         cathode <= {dp, blank_sel ? 7'h7F : seg};
      end
   end

endmodule
